// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port block-RAM between io, mem and if
//            requesters (io > mem > if, with an if starvation guard).
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_req_if,
  output logic              stall_req_mem,
  output logic              busy
);

  localparam int                c_SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_SC_W-1:0] c_STARVE_MAX = c_SC_W'(STARVE_MAX);
  localparam logic [1:0]        c_LAT_INIT   = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_IO  = 2'd0,
    OWN_MEM = 2'd1,
    OWN_IF  = 2'd2
  } owner_t;

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  owner_t              w_grant;
  logic                w_any_req;
  logic                w_starved;
  logic                w_lat_done;
  logic [c_SC_W-1:0]   r_starve_cnt;
  logic [1:0]          r_lat_cnt;
  logic                r_we;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;

  assign w_any_req  = io_req | mem_req | if_req;
  assign w_starved  = if_req && (r_starve_cnt == c_STARVE_MAX);
  assign w_lat_done = (r_lat_cnt == 2'd0);

  // A starved fetch outranks mem but never the loader.
  always_comb begin
    w_grant = OWN_IF;
    if (io_req)
      w_grant = OWN_IO;
    else if (w_starved)
      w_grant = OWN_IF;
    else if (mem_req)
      w_grant = OWN_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (w_lat_done) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWN_IO;
      r_starve_cnt <= '0;
      r_lat_cnt    <= 2'd0;
      r_we         <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner  <= w_grant;
            r_ram_en <= 1'b1;
            case (w_grant)
              OWN_IO: begin
                r_we        <= io_we;
                r_ram_we    <= io_we;
                r_ram_addr  <= io_addr;
                r_ram_wdata <= io_wdata;
              end
              OWN_MEM: begin
                r_we        <= mem_we;
                r_ram_we    <= mem_we;
                r_ram_addr  <= mem_addr;
                r_ram_wdata <= mem_wdata;
              end
              default: begin
                r_we        <= 1'b0;
                r_ram_we    <= 1'b0;
                r_ram_addr  <= if_addr;
                r_ram_wdata <= '0;
              end
            endcase
            if (!if_req || (w_grant == OWN_IF))
              r_starve_cnt <= '0;
            else if (r_starve_cnt != c_STARVE_MAX)
              r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        ISSUE: r_lat_cnt <= c_LAT_INIT;
        WAIT: begin
          if (w_lat_done) begin
            // Writes leave the requester's read-data register untouched.
            if (!r_we && (r_owner == OWN_IF))
              r_if_rdata <= ram_rdata;
            else if (!r_we && (r_owner == OWN_MEM))
              r_mem_rdata <= ram_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;

  assign io_ack  = (r_state == RESP) && (r_owner == OWN_IO);
  assign mem_ack = (r_state == RESP) && (r_owner == OWN_MEM);
  assign if_ack  = (r_state == RESP) && (r_owner == OWN_IF);
  assign busy    = (r_state != IDLE);

  assign stall_req_if  = if_req & ~if_ack;
  assign stall_req_mem = mem_req & ~mem_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Two arbiters (MEM_LAT 1 and 3) under directed and random traffic,
//            checked cycle by cycle against a transaction-timing model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int SM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_cmd;

  logic          if_req [2], if_ack [2], mem_req [2], mem_we [2], mem_ack [2];
  logic          io_req [2], io_we [2], io_ack [2], ram_en [2], ram_we [2];
  logic          stall_req_if [2], stall_req_mem [2], busy [2];
  logic [AW-1:0] if_addr [2], mem_addr [2], io_addr [2], ram_addr [2];
  logic [DW-1:0] if_rdata [2], mem_wdata [2], mem_rdata [2], io_wdata [2];
  logic [DW-1:0] ram_wdata [2], ram_rdata [2];

  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] init_fn(input int d, input logic [AW-1:0] a);
    if (a == 14'h010) return 32'hDEADBEEF;
    return 32'h9E3779B9 * (32'(a) + 32'(d) * 32'd7919 + 32'd1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0]  ram [16384];
    bit   [16383:0] wr_valid = '0;
    logic [DW-1:0]  pipe [LAT];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_ack(mem_ack[g]), .mem_rdata(mem_rdata[g]),
      .io_req(io_req[g]), .io_we(io_we[g]), .io_addr(io_addr[g]),
      .io_wdata(io_wdata[g]), .io_ack(io_ack[g]),
      .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g]),
      .stall_req_if(stall_req_if[g]), .stall_req_mem(stall_req_mem[g]), .busy(busy[g])
    );

    // Block-RAM model; junk is shifted in whenever no read is issued.
    always @(posedge clk) begin
      if (ram_en[g] && ram_we[g]) begin
        ram[ram_addr[g]]      <= ram_wdata[g];
        wr_valid[ram_addr[g]] <= 1'b1;
      end
      pipe[0] <= (ram_en[g] && !ram_we[g])
                 ? (wr_valid[ram_addr[g]] ? ram[ram_addr[g]] : init_fn(g, ram_addr[g]))
                 : $urandom;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rdata[g] = pipe[LAT-1];
  end

  int            cyc, nvec, nerr;
  logic [DW-1:0] ref_mem [int];
  int            m_dec [2], m_next [2], m_own [2], m_starve [2];
  logic          m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2], m_rval [2], e_if_rd [2], e_mem_rd [2];
  logic          a_if [2], a_mem [2], a_io [2];
  bit            p_if [2], p_mem [2], p_io [2], rand_mode;
  logic          p_mem_we [2], p_io_we [2];
  logic [AW-1:0] p_if_addr [2], p_mem_addr [2], p_io_addr [2];
  logic [DW-1:0] p_mem_wdata [2], p_io_wdata [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_dec[d] = -1000; m_next[d] = 0; m_starve[d] = 0;
      e_if_rd[d] = '0; e_mem_rd[d] = '0;
      a_if[d] = 1'b0; a_mem[d] = 1'b0; a_io[d] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input int d, input logic [AW-1:0] a);
    int key = d * 65536 + int'(a);
    return ref_mem.exists(key) ? ref_mem[key] : init_fn(d, a);
  endfunction

  task automatic eval(input int d);
    string s = $sformatf("d%0d", d);
    int lat = lat_of(d);
    logic en_exp, ack_c;
    logic [2:0] ack_exp;
    if (!rst_n) begin
      check({s, ".rst_ram"}, {ram_en[d], ram_we[d], ram_addr[d], ram_wdata[d]}, 64'd0);
      check({s, ".rst_ack"}, {io_ack[d], mem_ack[d], if_ack[d]}, 64'd0);
      check({s, ".rst_rdata"}, {if_rdata[d], mem_rdata[d]}, 64'd0);
      check({s, ".rst_busy"}, busy[d], 64'd0);
      a_if[d] = 1'b0; a_mem[d] = 1'b0; a_io[d] = 1'b0;
      return;
    end
    if (cyc >= m_next[d] && (io_req[d] || mem_req[d] || if_req[d])) begin
      if (io_req[d])                        m_own[d] = 0;
      else if (if_req[d] && m_starve[d] == SM) m_own[d] = 2;
      else if (mem_req[d])                  m_own[d] = 1;
      else                                  m_own[d] = 2;
      if (!if_req[d] || m_own[d] == 2) m_starve[d] = 0;
      else if (m_starve[d] < SM)       m_starve[d]++;
      case (m_own[d])
        0:       begin m_we[d] = io_we[d];  m_addr[d] = io_addr[d];  m_wdata[d] = io_wdata[d];  end
        1:       begin m_we[d] = mem_we[d]; m_addr[d] = mem_addr[d]; m_wdata[d] = mem_wdata[d]; end
        default: begin m_we[d] = 1'b0;      m_addr[d] = if_addr[d];  m_wdata[d] = '0;           end
      endcase
      if (m_we[d]) ref_mem[d * 65536 + int'(m_addr[d])] = m_wdata[d];
      else         m_rval[d] = ref_read(d, m_addr[d]);
      m_dec[d]  = cyc;
      m_next[d] = cyc + lat + 3;
    end
    en_exp  = (cyc == m_dec[d] + 1);
    ack_c   = (cyc == m_dec[d] + lat + 2);
    ack_exp = {ack_c && m_own[d] == 0, ack_c && m_own[d] == 1, ack_c && m_own[d] == 2};
    if (ack_c && !m_we[d]) begin
      if (m_own[d] == 2)      e_if_rd[d]  = m_rval[d];
      else if (m_own[d] == 1) e_mem_rd[d] = m_rval[d];
    end
    check({s, ".ram_en_we"}, {ram_en[d], ram_we[d]}, {en_exp, en_exp && m_we[d]});
    if (en_exp) check({s, ".ram_addr"}, ram_addr[d], m_addr[d]);
    if (en_exp && m_own[d] != 2) check({s, ".ram_wdata"}, ram_wdata[d], m_wdata[d]);
    check({s, ".acks"}, {io_ack[d], mem_ack[d], if_ack[d]}, ack_exp);
    check({s, ".if_rdata"}, if_rdata[d], e_if_rd[d]);
    check({s, ".mem_rdata"}, mem_rdata[d], e_mem_rd[d]);
    check({s, ".busy"}, busy[d], (cyc > m_dec[d]) && (cyc <= m_dec[d] + lat + 2));
    check({s, ".stall"}, {stall_req_if[d], stall_req_mem[d]},
          {if_req[d] & ~ack_exp[0], mem_req[d] & ~ack_exp[1]});
    a_io[d] = io_ack[d]; a_mem[d] = mem_ack[d]; a_if[d] = if_ack[d];
  endtask

  task automatic drive(input int d);
    if (a_if[d])  if_req[d]  = 1'b0;
    if (a_mem[d]) mem_req[d] = 1'b0;
    if (a_io[d])  io_req[d]  = 1'b0;
    if (p_if[d])  begin if_req[d] = 1'b1; if_addr[d] = p_if_addr[d]; p_if[d] = 0; end
    if (p_mem[d]) begin
      mem_req[d] = 1'b1; mem_we[d] = p_mem_we[d];
      mem_addr[d] = p_mem_addr[d]; mem_wdata[d] = p_mem_wdata[d]; p_mem[d] = 0;
    end
    if (p_io[d]) begin
      io_req[d] = 1'b1; io_we[d] = p_io_we[d];
      io_addr[d] = p_io_addr[d]; io_wdata[d] = p_io_wdata[d]; p_io[d] = 0;
    end
    if (rand_mode) begin
      if ($urandom_range(2) == 0) begin
        if (!if_req[d]) if_req[d] = 1'b1;
        if_addr[d] = AW'($urandom);
      end
      if ($urandom_range(2) == 0) begin
        if (!mem_req[d]) mem_req[d] = 1'b1;
        mem_we[d] = 1'($urandom); mem_addr[d] = AW'($urandom); mem_wdata[d] = $urandom;
      end
      if ($urandom_range(9) == 0) begin
        if (!io_req[d]) io_req[d] = 1'b1;
        io_we[d] = 1'($urandom); io_addr[d] = AW'($urandom); io_wdata[d] = $urandom;
      end
      // Occasional illegal early drop of the data request.
      if ($urandom_range(63) == 0) mem_req[d] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rst_cmd;
    for (int d = 0; d < 2; d++) drive(d);
    #1;
    for (int d = 0; d < 2; d++) eval(d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && (if_req[0] || mem_req[0] || io_req[0] || if_req[1] || mem_req[1] ||
           io_req[1] || p_if[0] || p_mem[0] || p_io[0] || p_if[1] || p_mem[1] || p_io[1] ||
           cyc < m_next[0] || cyc < m_next[1])) begin
      step();
      n++;
    end
    if (n >= budget) check("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nm, k;
    bit got_if;
    logic [AW-1:0] ra;
    cyc = 0; nvec = 0; nerr = 0; rand_mode = 0; rst_cmd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 0; mem_req[d] = 0; io_req[d] = 0; mem_we[d] = 0; io_we[d] = 0;
      if_addr[d] = '0; mem_addr[d] = '0; io_addr[d] = '0; mem_wdata[d] = '0; io_wdata[d] = '0;
      p_if[d] = 0; p_mem[d] = 0; p_io[d] = 0;
    end
    model_reset();
    repeat (3) step();
    rst_cmd = 1'b1;

    // Lone fetch (LAT 1) and a LAT 3 data read of 0x3FF.
    p_if[0] = 1; p_if_addr[0] = 14'h010;
    p_mem[1] = 1; p_mem_we[1] = 0; p_mem_addr[1] = 14'h3FF; p_mem_wdata[1] = '0;
    drain(50);
    check("fetch_data", if_rdata[0], 32'hDEADBEEF);
    check("lat3_data", mem_rdata[1], init_fn(1, 14'h3FF));

    // Fetch competing with a store, then read the store back.
    p_if[0] = 1; p_if_addr[0] = 14'h055;
    p_mem[0] = 1; p_mem_we[0] = 1; p_mem_addr[0] = 14'h020; p_mem_wdata[0] = 32'h12345678;
    drain(50);
    p_mem[0] = 1; p_mem_we[0] = 0; p_mem_addr[0] = 14'h020;
    drain(50);
    check("store_readback", mem_rdata[0], 32'h12345678);

    // All three requesters at once on both instances.
    for (int d = 0; d < 2; d++) begin
      p_io[d] = 1; p_io_we[d] = 1; p_io_addr[d] = AW'($urandom); p_io_wdata[d] = $urandom;
      p_mem[d] = 1; p_mem_we[d] = 0; p_mem_addr[d] = AW'($urandom);
      p_if[d] = 1; p_if_addr[d] = AW'($urandom);
    end
    drain(80);

    // Starvation: mem re-issues continuously while fetch waits.
    p_if[0] = 1; p_if_addr[0] = 14'h100;
    p_mem[0] = 1; p_mem_we[0] = 0; p_mem_addr[0] = 14'h200;
    nm = 0; got_if = 0; k = 0;
    while (k < 80 && !got_if) begin
      step();
      if (a_if[0]) got_if = 1;
      else if (a_mem[0]) begin
        nm++;
        p_mem[0] = 1; p_mem_we[0] = 1'($urandom);
        p_mem_addr[0] = AW'($urandom); p_mem_wdata[0] = $urandom;
      end
      k++;
    end
    check("starve_if_granted", got_if, 64'd1);
    check("starve_mem_wins", nm, 64'd3);
    drain(80);

    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    drain(200);

    // Reset in the middle of a LAT 3 read; the request stays up.
    ra = AW'($urandom);
    p_mem[1] = 1; p_mem_we[1] = 0; p_mem_addr[1] = ra;
    k = 0;
    do begin step(); k++; end while (cyc != m_dec[1] + 3 && k < 20);
    if (k >= 20) check("reset_setup_timeout", 64'd1, 64'd0);
    #3;
    rst_cmd = 1'b0;
    rst_n = 1'b0;
    #1;
    eval(0);
    eval(1);
    model_reset();
    repeat (2) step();
    rst_cmd = 1'b1;
    drain(50);
    check("reset_recover_data", mem_rdata[1], ref_read(1, ra));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port unified block-RAM between three requesters: UART/IO program loader (io), MEM-stage data access (mem) and IF-stage instruction fetch (if).
- Fixed priority is io > mem > if, with a starvation guard for if.
- Drives registered memory-side controls and returns read data with a one-cycle ack pulse.
- Pending requests are exported as stall_req_if / stall_req_mem to the CPU stall controller.

Parameters:
- ADDR_W, 14, word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata. Legal range is 1..4.
- STARVE_MAX, 3, number of consecutive lost arbitrations after which if outranks mem.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch word address; read-only.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetch data; valid while if_ack=1.
- mem_req  in  1  data request; held until mem_ack.
- mem_we  in  1  1=write, 0=read.
- mem_addr  in  ADDR_W  data word address.
- mem_wdata  in  DATA_W  store data.
- mem_ack  out  1  one-cycle completion pulse for data.
- mem_rdata  out  DATA_W  load data; valid while mem_ack=1.
- io_req  in  1  loader request; held until io_ack.
- io_we  in  1  loader write enable.
- io_addr  in  ADDR_W  loader address.
- io_wdata  in  DATA_W  loader write data.
- io_ack  out  1  one-cycle completion pulse for loader.
- ram_en  out  1  memory enable; registered.
- ram_we  out  1  memory write enable; registered.
- ram_addr  out  ADDR_W  memory address; registered.
- ram_wdata  out  DATA_W  memory write data; registered.
- ram_rdata  in  DATA_W  memory read data.
- stall_req_if  out  1  if_req & ~if_ack.
- stall_req_mem  out  1  mem_req & ~mem_ack.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock domain clk; rst_n is asynchronous, active-low.
- Reset values (rst_n=0, any time including mid-transaction):
  - state=IDLE, starve_cnt=0, lat_cnt=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - all acks=0, all rdata outputs=0, busy=0.
  - An in-flight transaction is abandoned with no ack; the requester re-arbitrates after reset release.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select owner, latch owner's we/addr/wdata (if is forced to we=0), load ram_* registers, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: ram_en=1 for exactly this cycle; load lat_cnt=MEM_LAT-1; go to WAIT.
- WAIT:
  - If lat_cnt=0: capture ram_rdata into owner's rdata register, go to RESP.
  - Otherwise decrement lat_cnt.
- RESP: owner's ack=1 for exactly this cycle; no arbitration; go to IDLE.
- Timing: grant decided in IDLE cycle t → ram_en in t+1 → ack in t+MEM_LAT+2 → next grant decision earliest at t+MEM_LAT+3.
  - Writes use identical timing; their rdata output is unchanged (holds previous value).
- Owner selection in IDLE:
  - io_req wins always.
  - else if if_req and starve_cnt==STARVE_MAX, if wins.
  - else mem_req wins.
  - else if_req wins.
- Starvation counter (updated only at IDLE decisions):
  - if if_req=1 and if loses, starve_cnt increments, saturating at STARVE_MAX.
  - if if wins or if_req=0, starve_cnt returns to 0.
- Request-field stability: requester fields are sampled only at grant; changes after grant are ignored.
- Illegal but tolerated: requester drops req before ack. Transaction still completes and the ack is still pulsed.
- ram_we=0 in every cycle except ISSUE of a write; ram_en=0 outside ISSUE.
- stall_req_* are combinational. They fall in the ack cycle so the CPU advances on the same edge the data is captured.

Test Plan:
- Reset then lone fetch: if_req=1, if_addr=0x010, ram returns 0xDEADBEEF, MEM_LAT=1.
  → ram_en high cycle 1 only, if_ack cycle 3 with if_rdata=0xDEADBEEF; stall_req_if high cycles 0–2, low in cycle 3.
- Simultaneous if_req and mem_req (mem_we=1, addr 0x020, wdata 0x12345678).
  → mem served first (ram_we=1, ram_addr=0x020, ram_wdata=0x12345678); mem_ack at cycle 3; if granted at cycle 4, if_ack at cycle 7.
- io_req asserted together with mem_req and if_req.
  → io granted first, io_ack before any mem_ack/if_ack, ram_we follows io_we.
- Starvation: mem_req held continuously with re-issued requests, if_req high, STARVE_MAX=3.
  → mem wins three decisions, fourth decision grants if, starve_cnt returns to 0.
- MEM_LAT=3 read of 0x3FF.
  → ack 5 cycles after grant decision; rdata captured from ram_rdata in the last WAIT cycle; ram_addr=0x3FF.
- rst_n pulled low during WAIT of a mem read.
  → all outputs 0 asynchronously, no mem_ack; after release with mem_req still high, fresh transaction completes normally.
